// File: rtl/lc3_pkg.sv
// Shared types and memory-mapped I/O addresses for the LC-3 memory responder.
package lc3_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

  localparam logic [15:0] IO_BASE   = 16'hFE00;
  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;
endpackage

// File: rtl/lc3_io_regs.sv
// Keyboard status/data capture and display output pulse for the LC-3 I/O page.
module lc3_io_regs (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_kb_valid,
  input  logic [7:0] i_kb_data,
  input  logic       i_kbdr_rd,
  input  logic       i_ddr_wr,
  input  logic [7:0] i_ddr_data,
  output logic       o_kbsr,
  output logic [7:0] o_kbdr,
  output logic       o_disp_valid,
  output logic [7:0] o_disp_data
);
  logic       r_kbsr;
  logic [7:0] r_kbdr;
  logic       r_disp_valid;
  logic [7:0] r_disp_data;
  logic       w_kb_load;

  // A KBDR read completing this cycle frees the slot, so a new key is accepted and set wins over clear.
  assign w_kb_load = i_kb_valid && (!r_kbsr || i_kbdr_rd);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_kbsr       <= 1'b0;
      r_kbdr       <= 8'h00;
      r_disp_valid <= 1'b0;
      r_disp_data  <= 8'h00;
    end else begin
      if (w_kb_load) begin
        r_kbdr <= i_kb_data;
        r_kbsr <= 1'b1;
      end else if (i_kbdr_rd) begin
        r_kbsr <= 1'b0;
      end
      r_disp_valid <= i_ddr_wr;
      if (i_ddr_wr) r_disp_data <= i_ddr_data;
    end
  end

  assign o_kbsr       = r_kbsr;
  assign o_kbdr       = r_kbdr;
  assign o_disp_valid = r_disp_valid;
  assign o_disp_data  = r_disp_data;
endmodule

// File: rtl/lc3_mem_responder.sv
// LC-3 memory responder: latency FSM, ready handshake, backing array and I/O page decode.
module lc3_mem_responder
  import lc3_pkg::*;
#(
  parameter int LATENCY   = 2,
  parameter int MEM_WORDS = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        ready,
  input  logic        kb_valid,
  input  logic [7:0]  kb_data,
  input  logic        disp_ready,
  output logic        disp_valid,
  output logic [7:0]  disp_data
);
  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  logic [15:0] mem [MEM_WORDS];

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [15:0] r_addr, r_wdata, r_rdata;

  logic        w_accept, w_enter_done, w_we, w_io, w_in_mem;
  logic [15:0] w_addr, w_wdata, w_rd_val;
  logic        w_kbsr, w_kbdr_rd, w_ddr_wr;
  logic [7:0]  w_kbdr;

  assign w_accept     = (r_state == ST_IDLE) && req_valid;
  assign w_enter_done = (w_accept && (LATENCY == 1)) || ((r_state == ST_BUSY) && (r_cnt == 4'd1));

  // With LATENCY=1 the access completes on the acceptance edge, before the request is registered.
  assign w_we    = (r_state == ST_IDLE) ? req_we : r_we;
  assign w_addr  = (r_state == ST_IDLE) ? addr   : r_addr;
  assign w_wdata = (r_state == ST_IDLE) ? wdata  : r_wdata;

  assign w_io     = (w_addr >= IO_BASE);
  assign w_in_mem = !w_io && ({16'd0, w_addr} < $unsigned(MEM_WORDS));

  assign w_kbdr_rd = w_enter_done && !w_we && (w_addr == KBDR_ADDR);
  assign w_ddr_wr  = w_enter_done &&  w_we && (w_addr == DDR_ADDR);

  always_comb begin
    w_rd_val = 16'h0000;
    if (w_io) begin
      case (w_addr)
        KBSR_ADDR: w_rd_val = {w_kbsr, 15'b0};
        KBDR_ADDR: w_rd_val = {8'b0, w_kbdr};
        DSR_ADDR:  w_rd_val = {disp_ready, 15'b0};
        default:   w_rd_val = 16'h0000;
      endcase
    end else if (w_in_mem) begin
      w_rd_val = mem[w_addr[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= 16'h0000;
      r_wdata <= 16'h0000;
      r_rdata <= 16'h0000;
    end else begin
      case (r_state)
        ST_IDLE: if (req_valid) begin
          r_we    <= req_we;
          r_addr  <= addr;
          r_wdata <= wdata;
          if (LATENCY == 1) r_state <= ST_DONE;
          else begin
            r_state <= ST_BUSY;
            r_cnt   <= 4'(LATENCY - 1);
          end
        end
        ST_BUSY: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= ST_DONE;
        end
        ST_DONE: if (!req_valid) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
      if (w_enter_done && !w_we) r_rdata <= w_rd_val;
    end
  end

  // Backing array is deliberately left uninitialised on reset.
  always_ff @(posedge clk) begin
    if (!rst && w_enter_done && w_we && w_in_mem) mem[w_addr[AW-1:0]] <= w_wdata;
  end

  lc3_io_regs u_io (
    .clk          (clk),
    .rst          (rst),
    .i_kb_valid   (kb_valid),
    .i_kb_data    (kb_data),
    .i_kbdr_rd    (w_kbdr_rd),
    .i_ddr_wr     (w_ddr_wr),
    .i_ddr_data   (w_wdata[7:0]),
    .o_kbsr       (w_kbsr),
    .o_kbdr       (w_kbdr),
    .o_disp_valid (disp_valid),
    .o_disp_data  (disp_data)
  );

  assign ready = (r_state == ST_DONE);
  assign rdata = r_rdata;
endmodule

// File: tb/tb_lc3_mem_responder.sv
// Directed bench for lc3_mem_responder with LATENCY 2 (u0), 1 (u1) and 4 (u2).
module tb_lc3_mem_responder;
  import lc3_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        kb_valid = 1'b0;
  logic [7:0]  kb_data = 8'h00;
  logic        disp_ready = 1'b0;
  logic        rv [3];
  logic        rwe [3];
  logic [15:0] ra [3];
  logic [15:0] rwd [3];
  logic [15:0] rd [3];
  logic        rdy [3];
  logic        dv [3];
  logic [7:0]  dd [3];
  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  lc3_mem_responder #(.LATENCY(2)) u0 (
    .clk(clk), .rst(rst), .req_valid(rv[0]), .req_we(rwe[0]), .addr(ra[0]), .wdata(rwd[0]),
    .rdata(rd[0]), .ready(rdy[0]), .kb_valid(kb_valid), .kb_data(kb_data),
    .disp_ready(disp_ready), .disp_valid(dv[0]), .disp_data(dd[0]));
  lc3_mem_responder #(.LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .req_valid(rv[1]), .req_we(rwe[1]), .addr(ra[1]), .wdata(rwd[1]),
    .rdata(rd[1]), .ready(rdy[1]), .kb_valid(kb_valid), .kb_data(kb_data),
    .disp_ready(disp_ready), .disp_valid(dv[1]), .disp_data(dd[1]));
  lc3_mem_responder #(.LATENCY(4)) u2 (
    .clk(clk), .rst(rst), .req_valid(rv[2]), .req_we(rwe[2]), .addr(ra[2]), .wdata(rwd[2]),
    .rdata(rd[2]), .ready(rdy[2]), .kb_valid(kb_valid), .kb_data(kb_data),
    .disp_ready(disp_ready), .disp_valid(dv[2]), .disp_data(dd[2]));

  // Issue one request on instance k; lat counts negedges after acceptance until ready is seen.
  task automatic do_req(input int k, input logic we, input logic [15:0] a, input logic [15:0] d,
                        input int hold, output int lat, output logic [15:0] data,
                        output logic held_ok, output logic rdy_after);
    @(negedge clk);
    rv[k] = 1'b1; rwe[k] = we; ra[k] = a; rwd[k] = d;
    @(posedge clk);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rdy[k] && lat < 40);
    data = rd[k];
    held_ok = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      if (!rdy[k] || rd[k] !== data) held_ok = 1'b0;
    end
    rv[k] = 1'b0; rwe[k] = 1'b0;
    @(posedge clk);
    #1 rdy_after = rdy[k];
  endtask

  task automatic kb_pulse(input logic [7:0] c);
    @(negedge clk); kb_valid = 1'b1; kb_data = c;
    @(negedge clk); kb_valid = 1'b0;
  endtask

  task automatic ddr_write(input logic [15:0] d, output int pulses, output logic [7:0] cap);
    pulses = 0; cap = 8'h00;
    @(negedge clk);
    rv[0] = 1'b1; rwe[0] = 1'b1; ra[0] = DDR_ADDR; rwd[0] = d;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (dv[0]) begin pulses++; cap = dd[0]; end
      if (rdy[0]) begin rv[0] = 1'b0; rwe[0] = 1'b0; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++; if (rdy[0] !== 1'b0) $display("FAIL reset_ready: got %b expected 0", rdy[0]); else n_pass++;
    n_total++; if (rd[0] !== 16'h0000) $display("FAIL reset_rdata: got %h expected 0000", rd[0]); else n_pass++;
    n_total++; if (dv[0] !== 1'b0 || dd[0] !== 8'h00) $display("FAIL reset_disp: got %b/%h expected 0/00", dv[0], dd[0]); else n_pass++;
    n_total++; if (u0.r_state !== ST_IDLE) $display("FAIL reset_state: got %0d expected %0d", u0.r_state, ST_IDLE); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_read_latency();
    int lat; logic [15:0] data; logic ok, ra_;
    u0.mem[16'h000B] = 16'd12;
    do_req(0, 1'b0, 16'h000B, 16'h0000, 0, lat, data, ok, ra_);
    n_total++; if (lat !== 2) $display("FAIL read_lat: got %0d expected 2", lat); else n_pass++;
    n_total++; if (data !== 16'd12) $display("FAIL read_data: got %h expected 000c", data); else n_pass++;
    n_total++; if (ra_ !== 1'b0) $display("FAIL read_ready_fall: got %b expected 0", ra_); else n_pass++;
  endtask

  task automatic test_write_read();
    int lat; logic [15:0] data; logic ok, ra_;
    do_req(0, 1'b1, 16'h0030, 16'h1234, 0, lat, data, ok, ra_);
    n_total++; if (lat !== 2) $display("FAIL write_lat: got %0d expected 2", lat); else n_pass++;
    do_req(0, 1'b0, 16'h0030, 16'h0000, 0, lat, data, ok, ra_);
    n_total++; if (data !== 16'h1234) $display("FAIL wr_rd_data: got %h expected 1234", data); else n_pass++;
    do_req(1, 1'b1, 16'h0030, 16'h1234, 0, lat, data, ok, ra_);
    do_req(1, 1'b0, 16'h0030, 16'h0000, 0, lat, data, ok, ra_);
    n_total++; if (lat !== 1) $display("FAIL l1_lat: got %0d expected 1", lat); else n_pass++;
    n_total++; if (data !== 16'h1234) $display("FAIL l1_data: got %h expected 1234", data); else n_pass++;
    do_req(0, 1'b0, 16'hFF10, 16'h0000, 0, lat, data, ok, ra_);
    n_total++; if (data !== 16'h0000) $display("FAIL io_hole: got %h expected 0000", data); else n_pass++;
  endtask

  task automatic test_hold();
    int lat; logic [15:0] data; logic ok, ra_;
    int lats [2] = '{1, 4};
    u1.mem[16'h0100] = 16'hA5A5;
    u2.mem[16'h0100] = 16'h5A5A;
    for (int k = 1; k < 3; k++) begin
      do_req(k, 1'b0, 16'h0100, 16'h0000, 3, lat, data, ok, ra_);
      n_total++; if (lat !== lats[k-1]) $display("FAIL hold_lat%0d: got %0d expected %0d", k, lat, lats[k-1]); else n_pass++;
      n_total++; if (data !== ((k == 1) ? 16'hA5A5 : 16'h5A5A)) $display("FAIL hold_data%0d: got %h", k, data); else n_pass++;
      n_total++; if (ok !== 1'b1) $display("FAIL hold_ready%0d: got %b expected 1", k, ok); else n_pass++;
      n_total++; if (ra_ !== 1'b0) $display("FAIL hold_drop%0d: got %b expected 0", k, ra_); else n_pass++;
      @(negedge clk);
      n_total++; if (rdy[k] !== 1'b0) $display("FAIL hold_idle%0d: got %b expected 0", k, rdy[k]); else n_pass++;
    end
  endtask

  task automatic test_keyboard();
    int lat; logic [15:0] data; logic ok, ra_;
    kb_pulse(8'h41);
    do_req(0, 1'b0, KBSR_ADDR, 16'h0000, 0, lat, data, ok, ra_);
    n_total++; if (data !== 16'h8000) $display("FAIL kbsr_set: got %h expected 8000", data); else n_pass++;
    kb_pulse(8'h42);
    do_req(0, 1'b1, KBDR_ADDR, 16'h7777, 0, lat, data, ok, ra_);
    do_req(0, 1'b0, KBDR_ADDR, 16'h0000, 0, lat, data, ok, ra_);
    n_total++; if (data !== 16'h0041) $display("FAIL kbdr_data: got %h expected 0041", data); else n_pass++;
    do_req(0, 1'b0, KBSR_ADDR, 16'h0000, 0, lat, data, ok, ra_);
    n_total++; if (data !== 16'h0000) $display("FAIL kbsr_clr: got %h expected 0000", data); else n_pass++;
    // key arrives on the same edge a KBDR read completes
    kb_pulse(8'h43);
    @(negedge clk); rv[0] = 1'b1; rwe[0] = 1'b0; ra[0] = KBDR_ADDR;
    @(posedge clk);
    @(negedge clk); kb_valid = 1'b1; kb_data = 8'h44;
    @(negedge clk); kb_valid = 1'b0;
    n_total++; if (rdy[0] !== 1'b1 || rd[0] !== 16'h0043) $display("FAIL kb_race_old: got %b/%h expected 1/0043", rdy[0], rd[0]); else n_pass++;
    rv[0] = 1'b0;
    @(posedge clk);
    do_req(0, 1'b0, KBSR_ADDR, 16'h0000, 0, lat, data, ok, ra_);
    n_total++; if (data !== 16'h8000) $display("FAIL kb_race_sr: got %h expected 8000", data); else n_pass++;
    do_req(0, 1'b0, KBDR_ADDR, 16'h0000, 0, lat, data, ok, ra_);
    n_total++; if (data !== 16'h0044) $display("FAIL kb_race_dr: got %h expected 0044", data); else n_pass++;
  endtask

  task automatic test_display();
    int lat, pulses; logic [15:0] data; logic ok, ra_; logic [7:0] cap;
    u0.mem[16'hFE06] = 16'hBEEF;
    disp_ready = 1'b1;
    do_req(0, 1'b0, DSR_ADDR, 16'h0000, 0, lat, data, ok, ra_);
    n_total++; if (data !== 16'h8000) $display("FAIL dsr_rdy: got %h expected 8000", data); else n_pass++;
    disp_ready = 1'b0;
    do_req(0, 1'b0, DSR_ADDR, 16'h0000, 0, lat, data, ok, ra_);
    n_total++; if (data !== 16'h0000) $display("FAIL dsr_busy: got %h expected 0000", data); else n_pass++;
    disp_ready = 1'b1;
    ddr_write(16'h0048, pulses, cap);
    n_total++; if (pulses !== 1) $display("FAIL ddr_pulses: got %0d expected 1", pulses); else n_pass++;
    n_total++; if (cap !== 8'h48) $display("FAIL ddr_data: got %h expected 48", cap); else n_pass++;
    n_total++; if (u0.mem[16'hFE06] !== 16'hBEEF) $display("FAIL ddr_mem: got %h expected beef", u0.mem[16'hFE06]); else n_pass++;
    disp_ready = 1'b0;
    ddr_write(16'h0049, pulses, cap);
    n_total++; if (pulses !== 1 || cap !== 8'h49) $display("FAIL ddr_notready: got %0d/%h expected 1/49", pulses, cap); else n_pass++;
  endtask

  task automatic test_abort();
    int lat; logic [15:0] data; logic ok, ra_;
    u0.mem[16'h0005] = 16'd7;
    do_req(0, 1'b0, 16'h000B, 16'h0000, 0, lat, data, ok, ra_);
    kb_pulse(8'h55);
    @(negedge clk); rv[0] = 1'b1; rwe[0] = 1'b1; ra[0] = 16'h0005; rwd[0] = 16'h9999;
    @(posedge clk);
    @(negedge clk); rst = 1'b1; rv[0] = 1'b0; rwe[0] = 1'b0;
    @(posedge clk);
    #1;
    n_total++; if (rdy[0] !== 1'b0) $display("FAIL abort_ready: got %b expected 0", rdy[0]); else n_pass++;
    n_total++; if (rd[0] !== 16'h0000) $display("FAIL abort_rdata: got %h expected 0000", rd[0]); else n_pass++;
    n_total++; if (u0.r_state !== ST_IDLE) $display("FAIL abort_state: got %0d expected %0d", u0.r_state, ST_IDLE); else n_pass++;
    n_total++; if (u0.mem[16'h0005] !== 16'd7) $display("FAIL abort_mem: got %h expected 0007", u0.mem[16'h0005]); else n_pass++;
    @(negedge clk); rst = 1'b0;
    do_req(0, 1'b0, KBSR_ADDR, 16'h0000, 0, lat, data, ok, ra_);
    n_total++; if (data !== 16'h0000) $display("FAIL abort_kbsr: got %h expected 0000", data); else n_pass++;
    do_req(0, 1'b0, 16'h0005, 16'h0000, 0, lat, data, ok, ra_);
    n_total++; if (lat !== 2 || data !== 16'd7) $display("FAIL abort_next: got %0d/%h expected 2/0007", lat, data); else n_pass++;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rv[k] = 1'b0; rwe[k] = 1'b0; ra[k] = 16'h0000; rwd[k] = 16'h0000;
    end
    test_reset();
    test_read_latency();
    test_write_read();
    test_hold();
    test_keyboard();
    test_display();
    test_abort();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
